// File: rtl/mask_scan_encoder_if.sv
// Mask scan encoder bus: mask load request side and
// register-index valid/ready output side.
interface mask_scan_encoder_if #(
  parameter int WIDTH    = 32,
  parameter int IDX_BITS = 5
);
  logic                load;
  logic [WIDTH-1:0]    mask_in;
  logic                busy;
  logic                out_valid;
  logic                out_ready;
  logic [IDX_BITS-1:0] out_idx;
  logic [IDX_BITS:0]   pending_cnt;
  logic                done;

  modport master (
    output load,
    output mask_in,
    output out_ready,
    input  busy,
    input  out_valid,
    input  out_idx,
    input  pending_cnt,
    input  done
  );

  modport slave (
    input  load,
    input  mask_in,
    input  out_ready,
    output busy,
    output out_valid,
    output out_idx,
    output pending_cnt,
    output done
  );
endinterface

// File: rtl/mask_scan_encoder.sv
// Multi-hot register mask to index stream, one index per handshake.
// SCAN_MSB_FIRST_EN: emit highest set bit first (descending order).
module mask_scan_encoder #(
  parameter int WIDTH    = 32,
  parameter int IDX_BITS = 5
) (
  input logic              clk,
  input logic              reset,
  mask_scan_encoder_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [WIDTH-1:0]    pending;
  logic [WIDTH-1:0]    pending_nxt;
  logic [IDX_BITS-1:0] sel;
  logic [IDX_BITS:0]   cnt;

  // Priority select from the registered mask only.
  always_comb begin
    sel = '0;
`ifdef SCAN_MSB_FIRST_EN
    for (int i = 0; i < WIDTH; i++) begin
      if (pending[i]) sel = IDX_BITS'(i);
    end
`else
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending[i]) sel = IDX_BITS'(i);
    end
`endif
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + {{IDX_BITS{1'b0}}, pending[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pending <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    unique case (state)
      IDLE: begin
        if (bus.load) begin
          pending_nxt = bus.mask_in;
          state_nxt   = (|bus.mask_in) ? SCAN : DONE;
        end
      end
      SCAN: begin
        if (bus.out_ready) begin
          pending_nxt = pending & ~(WIDTH'(1) << sel);
          if (cnt == (IDX_BITS + 1)'(1)) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy        = (state == SCAN);
  assign bus.out_valid   = (state == SCAN);
  assign bus.out_idx     = (state == SCAN) ? sel : '0;
  assign bus.pending_cnt = cnt;
  assign bus.done        = (state == DONE);
endmodule

// File: tb/tb_mask_scan_encoder.sv
// Bench for mask_scan_encoder: queue model checked every cycle,
// plus directed literal expectations per scenario.
module tb_mask_scan_encoder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  mask_scan_encoder_if #(.WIDTH(32), .IDX_BITS(5)) bus ();

  mask_scan_encoder #(.WIDTH(32), .IDX_BITS(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: the remaining index stream as a queue.
  int q[$];
  int acc[$];
  bit scanning = 1'b0;
  bit exp_done = 1'b0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  function automatic void build(logic [31:0] m);
    q.delete();
`ifdef SCAN_MSB_FIRST_EN
    for (int i = 31; i >= 0; i--) if (m[i]) q.push_back(i);
`else
    for (int i = 0; i < 32; i++) if (m[i]) q.push_back(i);
`endif
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      scanning = 1'b0;
      exp_done = 1'b0;
    end else if (exp_done) begin
      exp_done = 1'b0;
    end else if (scanning) begin
      if (bus.out_ready) begin
        acc.push_back(q.pop_front());
        if (q.size() == 0) begin
          scanning = 1'b0;
          exp_done = 1'b1;
        end
      end
    end else if (bus.load) begin
      build(bus.mask_in);
      if (q.size() == 0) exp_done = 1'b1;
      else scanning = 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("busy", 32'(bus.busy), 32'(scanning));
    chk("out_valid", 32'(bus.out_valid), 32'(scanning));
    chk("out_idx", 32'(bus.out_idx),
        scanning ? 32'(q[0]) : 32'd0);
    chk("pending_cnt", 32'(bus.pending_cnt), 32'(q.size()));
    chk("done", 32'(bus.done), 32'(exp_done));
  end

  task automatic load_mask(logic [31:0] m);
    @(negedge clk);
    bus.load    = 1'b1;
    bus.mask_in = m;
    @(negedge clk);
    bus.load    = 1'b0;
    bus.mask_in = '0;
  endtask

  task automatic wait_done(string name, int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic chk_acc(string name, int exp[$]);
    chk({name, "_count"}, 32'(acc.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < acc.size(); i++)
      chk({name, "_idx"}, 32'(acc[i]), 32'(exp[i]));
  endtask

  initial begin
    int e[$];
    bus.load      = 1'b0;
    bus.mask_in   = '0;
    bus.out_ready = 1'b1;
    reset         = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_cnt", 32'(bus.pending_cnt), 32'd0);
    chk("idle_valid", 32'(bus.out_valid), 32'd0);

    // Sparse mask, ready held high.
    acc.delete();
    load_mask(32'h8001_0005);
    chk("sparse_cnt0", 32'(bus.pending_cnt), 32'd4);
`ifdef SCAN_MSB_FIRST_EN
    chk("sparse_idx0", 32'(bus.out_idx), 32'd31);
    e = '{31, 16, 2, 0};
`else
    chk("sparse_idx0", 32'(bus.out_idx), 32'd0);
    e = '{0, 2, 16, 31};
`endif
    @(negedge clk);
    chk("sparse_cnt1", 32'(bus.pending_cnt), 32'd3);
    wait_done("sparse", 10);
    chk("sparse_busy_at_done", 32'(bus.busy), 32'd0);
    chk_acc("sparse", e);

    // Backpressure.
    acc.delete();
    bus.out_ready = 1'b0;
    load_mask(32'h0000_0300);
    for (int i = 0; i < 3; i++) begin
`ifdef SCAN_MSB_FIRST_EN
      chk("bp_hold_idx", 32'(bus.out_idx), 32'd9);
`else
      chk("bp_hold_idx", 32'(bus.out_idx), 32'd8);
`endif
      chk("bp_hold_cnt", 32'(bus.pending_cnt), 32'd2);
      if (i < 2) @(negedge clk);
    end
    bus.out_ready = 1'b1;
    wait_done("bp", 10);
`ifdef SCAN_MSB_FIRST_EN
    e = '{9, 8};
`else
    e = '{8, 9};
`endif
    chk_acc("bp", e);

    // Full mask.
    acc.delete();
    load_mask(32'hFFFF_FFFF);
    chk("full_cnt0", 32'(bus.pending_cnt), 32'd32);
    wait_done("full", 40);
    e.delete();
`ifdef SCAN_MSB_FIRST_EN
    for (int i = 31; i >= 0; i--) e.push_back(i);
`else
    for (int i = 0; i < 32; i++) e.push_back(i);
`endif
    chk_acc("full", e);

    // Single top bit.
    acc.delete();
    load_mask(32'h8000_0000);
    chk("top_idx", 32'(bus.out_idx), 32'd31);
    wait_done("top", 5);
    e = '{31};
    chk_acc("top", e);

    // Empty mask.
    acc.delete();
    load_mask(32'h0);
    chk("empty_done", 32'(bus.done), 32'd1);
    chk("empty_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("empty_done_gone", 32'(bus.done), 32'd0);
    chk("empty_acc", 32'(acc.size()), 32'd0);

    // Load while busy is ignored.
    acc.delete();
    load_mask(32'h0000_00F0);
    bus.load    = 1'b1;
    bus.mask_in = 32'h1;
    @(negedge clk);
    bus.load    = 1'b0;
    bus.mask_in = '0;
    wait_done("lwb", 10);
`ifdef SCAN_MSB_FIRST_EN
    e = '{7, 6, 5, 4};
`else
    e = '{4, 5, 6, 7};
`endif
    chk_acc("lwb", e);

    // Reset after the second index is accepted.
    acc.delete();
    load_mask(32'h0000_00F0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_idx", 32'(bus.out_idx), 32'd0);
    chk("rst_cnt", 32'(bus.pending_cnt), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_acc", 32'(acc.size()), 32'd2);
    repeat (3) @(negedge clk);
    chk("rst_no_done", 32'(bus.done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
